mest_pro_exec_pipe: RTL
=======================

// Module: mest_pro_exec_pipe
// PURPOSE
//  Parametrised execute stage for the MESTPro core; successor to the single-cycle ALU stage.
//  Sits between decode and writeback/PC logic, accepting one instruction per i_execute/o_ready handshake.
//  Adds configurable data width, an iterative DATA_W-cycle shift-add multiplier with full-width product,
//  correct borrow/shift-out carry semantics and a sticky halt state.
// PARAMETERS
//  DATA_W    8  operand/result width in bits (>=4)
//  OPCODE_W  5  opcode width; opcode values from opcodes.vh (`OP_*)
//  CNT_W     $clog2(DATA_W+1)  multiplier iteration counter width (derived, do not override)
// PORTS
//  clk            in   1         core clock, rising edge
//  i_reset_n      in   1         asynchronous active-low reset
//  i_execute      in   1         instruction valid; accepted only when o_ready=1
//  i_op_code      in   OPCODE_W  opcode, sampled on accept
//  i_operand1     in   DATA_W    operand A, sampled on accept
//  i_operand2     in   DATA_W    operand B, sampled on accept
//  o_ready        out  1         stage idle and not halted; combinational from state
//  o_exec_done    out  1         one-cycle pulse: results/controls below are valid
//  o_result       out  DATA_W    result (low half of product for multiply)
//  o_result_hi    out  DATA_W    high half of product; 0 for all other ops
//  o_carry        out  1         carry/borrow/shift-out flag
//  o_zero_flag    out  1         o_result == 0 (DATA_W bits only; carry excluded)
//  o_jump         out  1         one-cycle pulse with o_exec_done for `OP_JMP
//  o_return_pc    out  1         one-cycle pulse with o_exec_done for `OP_RET
//  o_end_of_code  out  1         sticky; set by `OP_HALT
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; o_ready=1. Reset mid-multiply aborts it, no o_exec_done.
//  States: IDLE, MUL, HALTED. o_ready=1 only in IDLE.
//  IDLE, i_execute=1: latch opcode/operands. Non-multiply ops: results, flags, o_exec_done
//   registered at that same edge (latency 1). `OP_MULTIPLY: go to MUL, cnt=0, acc=0.
//  MUL: each cycle, if mult[cnt]=1 acc += mcand<<cnt (2*DATA_W bits); cnt++. After DATA_W
//   iterations (edge DATA_W after accept) write product, pulse o_exec_done, return to IDLE.
//   Multiply latency = DATA_W+1 edges from accept edge; o_ready=0 throughout.
//  i_execute while o_ready=0 is ignored (not queued); upstream must hold until accepted.
//  Arithmetic (A=i_operand1, B=i_operand2, width DATA_W):
//   ADD: {carry,res}=A+B.  SUB: {carry,res}={1'b0,A}-{1'b0,B}; carry=1 means borrow (A<B).
//   AND/OR/XOR: bitwise, carry=0.  NEGOP1: ~A, carry=0.
//   SLOP1: res=A<<1, carry=A[DATA_W-1].  SROP1: res=A>>1 (logical), carry=A[0].
//   MULTIPLY: {o_result_hi,o_result}=A*B unsigned; carry=|o_result_hi; zero uses low half only.
//  JMP/RET: pulse o_jump/o_return_pc with o_exec_done; o_result/o_carry/o_zero_flag hold.
//  HALT: o_exec_done pulse, o_end_of_code=1, enter HALTED; stay until reset, all i_execute ignored.
//  Unknown opcode: treated as NOP -- o_exec_done pulses, result/flags hold.
//  o_result, o_result_hi, o_carry, o_zero_flag hold between operations.
//  o_exec_done, o_jump, o_return_pc are never high two consecutive cycles without a new accept.
//  No combinational path from i_* to any output except none; o_ready depends on state only.
// TESTING (DATA_W=8)
//  ADD 0xF0+0x20 -> next edge o_result=0x10, o_carry=1, o_zero_flag=0, o_exec_done 1 cycle.
//  SUB 0x05-0x05 -> result 0x00, carry 0, zero 1; SUB 0x03-0x05 -> result 0xFE, carry 1.
//  MULTIPLY 0xFF*0xFF -> o_ready low 8 cycles, done at edge 9: hi=0xFE, lo=0x01, carry 1;
//   i_execute ADD asserted during MUL is ignored (no extra done).
//  SLOP1 0x81 -> 0x02 carry 1; SROP1 0x01 -> 0x00 carry 1 zero 1.
//  JMP then RET back-to-back -> o_jump then o_return_pc single pulses, prior ADD flags held.
//  HALT -> o_end_of_code=1, o_ready=0, later ADD ignored; reset mid-MUL -> all outputs 0, o_ready=1.

Source files
------------

// File: rtl/mest_pro_exec_pipe.sv
// MESTPro execute stage: single-cycle ALU ops, iterative shift-add multiply, sticky halt.
// The opcode package lives here so the bench and any decoder share one set of encodings.
package mest_pro_pkg;
   localparam int OP_NOP      = 0;
   localparam int OP_ADD      = 1;
   localparam int OP_SUB      = 2;
   localparam int OP_AND      = 3;
   localparam int OP_OR       = 4;
   localparam int OP_XOR      = 5;
   localparam int OP_NEGOP1   = 6;
   localparam int OP_SLOP1    = 7;
   localparam int OP_SROP1    = 8;
   localparam int OP_MULTIPLY = 9;
   localparam int OP_JMP      = 10;
   localparam int OP_RET      = 11;
   localparam int OP_HALT     = 12;
endpackage

module mest_pro_exec_pipe
   import mest_pro_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int OPCODE_W   = 5,
   localparam int CNT_W     = $clog2(DATA_W + 1)
) (
   input  logic                clk,
   input  logic                i_reset_n,
   input  logic                i_execute,
   input  logic [OPCODE_W-1:0] i_op_code,
   input  logic [DATA_W-1:0]   i_operand1,
   input  logic [DATA_W-1:0]   i_operand2,
   output logic                o_ready,
   output logic                o_exec_done,
   output logic [DATA_W-1:0]   o_result,
   output logic [DATA_W-1:0]   o_result_hi,
   output logic                o_carry,
   output logic                o_zero_flag,
   output logic                o_jump,
   output logic                o_return_pc,
   output logic                o_end_of_code
);

   typedef enum logic [1:0] {IDLE, MUL, HALTED} state_t;

   state_t              state;
   logic [2*DATA_W-1:0] mcand;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   mult;
   logic [CNT_W-1:0]    cnt;

   logic [DATA_W-1:0]   alu_res;
   logic                alu_carry;
   logic                alu_wr;
   logic                is_mul, is_jmp, is_ret, is_halt;
   logic [DATA_W:0]     sum, diff;
   logic [2*DATA_W-1:0] mul_sum;

   assign o_ready = (state == IDLE);

   // Multiplicand shifts left and multiplier shifts right each step, so bit 0 is mult[cnt].
   assign mul_sum = acc + (mult[0] ? mcand : '0);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      alu_res   = o_result;
      alu_carry = o_carry;
      alu_wr    = 1'b0;
      is_mul    = 1'b0;
      is_jmp    = 1'b0;
      is_ret    = 1'b0;
      is_halt   = 1'b0;
      sum       = {1'b0, i_operand1} + {1'b0, i_operand2};
      diff      = {1'b0, i_operand1} - {1'b0, i_operand2};
      case (int'(i_op_code))
         OP_ADD:      begin alu_res = sum[DATA_W-1:0];  alu_carry = sum[DATA_W];  alu_wr = 1'b1; end
         OP_SUB:      begin alu_res = diff[DATA_W-1:0]; alu_carry = diff[DATA_W]; alu_wr = 1'b1; end
         OP_AND:      begin alu_res = i_operand1 & i_operand2; alu_carry = 1'b0; alu_wr = 1'b1; end
         OP_OR:       begin alu_res = i_operand1 | i_operand2; alu_carry = 1'b0; alu_wr = 1'b1; end
         OP_XOR:      begin alu_res = i_operand1 ^ i_operand2; alu_carry = 1'b0; alu_wr = 1'b1; end
         OP_NEGOP1:   begin alu_res = ~i_operand1; alu_carry = 1'b0; alu_wr = 1'b1; end
         OP_SLOP1:    begin
            alu_res   = {i_operand1[DATA_W-2:0], 1'b0};
            alu_carry = i_operand1[DATA_W-1];
            alu_wr    = 1'b1;
         end
         OP_SROP1:    begin
            alu_res   = {1'b0, i_operand1[DATA_W-1:1]};
            alu_carry = i_operand1[0];
            alu_wr    = 1'b1;
         end
         OP_MULTIPLY: is_mul  = 1'b1;
         OP_JMP:      is_jmp  = 1'b1;
         OP_RET:      is_ret  = 1'b1;
         OP_HALT:     is_halt = 1'b1;
         default:     ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= IDLE;
         mcand         <= '0;
         acc           <= '0;
         mult          <= '0;
         cnt           <= '0;
         o_exec_done   <= 1'b0;
         o_result      <= '0;
         o_result_hi   <= '0;
         o_carry       <= 1'b0;
         o_zero_flag   <= 1'b0;
         o_jump        <= 1'b0;
         o_return_pc   <= 1'b0;
         o_end_of_code <= 1'b0;
      end else begin
         o_exec_done <= 1'b0;
         o_jump      <= 1'b0;
         o_return_pc <= 1'b0;
         case (state)
            IDLE: begin
               if (i_execute) begin
                  if (is_mul) begin
                     state <= MUL;
                     mcand <= {{DATA_W{1'b0}}, i_operand1};
                     mult  <= i_operand2;
                     acc   <= '0;
                     cnt   <= '0;
                  end else begin
                     o_exec_done <= 1'b1;
                     o_jump      <= is_jmp;
                     o_return_pc <= is_ret;
                     if (alu_wr) begin
                        o_result    <= alu_res;
                        o_result_hi <= '0;
                        o_carry     <= alu_carry;
                        o_zero_flag <= (alu_res == '0);
                     end
                     if (is_halt) begin
                        o_end_of_code <= 1'b1;
                        state         <= HALTED;
                     end
                  end
               end
            end
            MUL: begin
               acc   <= mul_sum;
               mcand <= mcand << 1;
               mult  <= mult >> 1;
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  o_result    <= mul_sum[DATA_W-1:0];
                  o_result_hi <= mul_sum[2*DATA_W-1:DATA_W];
                  o_carry     <= |mul_sum[2*DATA_W-1:DATA_W];
                  o_zero_flag <= (mul_sum[DATA_W-1:0] == '0);
                  o_exec_done <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HALTED:  ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
